// File: rtl/pkt_comm_pkg.sv
// Shared constants and types for the packet-communication input path.
package pkt_comm_pkg;

    localparam logic [7:0] PKT_TYPE_WORD_LIST  = 8'd1;
    localparam logic [7:0] PKT_TYPE_WORD_GEN   = 8'd2;
    localparam logic [7:0] PKT_TYPE_CMP_CONFIG = 8'd3;

    localparam int unsigned HDR_LEN   = 10;
    localparam int unsigned CKSUM_LEN = 4;

    localparam int unsigned ERR_VERSION    = 0;
    localparam int unsigned ERR_TYPE       = 1;
    localparam int unsigned ERR_LEN        = 2;
    localparam int unsigned ERR_HDR_CKSUM  = 3;
    localparam int unsigned ERR_BODY_CKSUM = 4;

    typedef enum logic [2:0] {
        StHdr,
        StHck,
        StBody,
        StBck,
        StErr
    } state_e;

    // One-hot consumer select; zero for an unknown type.
    function automatic logic [2:0] type_mask(input logic [7:0] t);
        logic [2:0] m;
        m = 3'b000;
        if (t == PKT_TYPE_WORD_LIST)  m = 3'b001;
        if (t == PKT_TYPE_WORD_GEN)   m = 3'b010;
        if (t == PKT_TYPE_CMP_CONFIG) m = 3'b100;
        return m;
    endfunction

endpackage

// File: rtl/pkt_comm_dispatch_if.sv
// Byte stream from the input FIFO, consumer strobes and per-packet status.
interface pkt_comm_dispatch_if;

    logic [7:0]  din;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout;
    logic [2:0]  wr_en;
    logic [2:0]  full;
    logic [15:0] pkt_id;
    logic [2:0]  pkt_done;
    logic        pkt_ok;
    logic [7:0]  err;

    // master: the dispatcher; slave: FIFO, consumers and status register side.
    modport master (
        input  din, empty, full,
        output rd_en, dout, wr_en, pkt_id, pkt_done, pkt_ok, err
    );

    modport slave (
        output din, empty, full,
        input  rd_en, dout, wr_en, pkt_id, pkt_done, pkt_ok, err
    );

endinterface

// File: rtl/pkt_comm_cksum32.sv
// 32-bit byte-sum accumulator; match compares the one's complement of the sum.
module pkt_comm_cksum32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [7:0]  data,
    input  logic [31:0] expected,
    output logic        match
);

    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (add) begin
            sum_q <= sum_q + {24'd0, data};
        end
    end

    assign match = (~sum_q == expected);

endmodule

// File: rtl/pkt_comm_dispatch.sv
// Parses packet headers from the input FIFO, steers bodies to one of three
// consumers and checks header and body checksums.
module pkt_comm_dispatch
    import pkt_comm_pkg::*;
#(
    parameter int unsigned VERSION          = 2,
    parameter int unsigned MAX_LEN          = 65536,
    parameter bit          DISABLE_CHECKSUM = 1'b0
) (
    input logic                 CLK,
    input logic                 RESET_N,
    pkt_comm_dispatch_if.master bus
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] rem_q, rem_d;
    logic [7:0]  ver_q, ver_d;
    logic [7:0]  typ_q, typ_d;
    logic [23:0] len_q, len_d;
    logic [7:0]  id0_q, id0_d;
    logic [7:0]  id1_q, id1_d;
    logic [15:0] pkt_id_q, pkt_id_d;
    logic [23:0] cks_q, cks_d;
    logic [2:0]  cons_q, cons_d;
    logic [2:0]  done_q, done_d;
    logic        ok_q, ok_d;
    logic [7:0]  err_q, err_d;

    logic        rd;
    logic [2:0]  wr;
    logic        ck_clr, ck_add, ck_match;
    logic [31:0] ck_ref;
    logic [4:0]  hdr_err;

    // Checksum bytes arrive little-endian; the 4th byte completes the word.
    assign ck_ref = {bus.din, cks_q};

    pkt_comm_cksum32 u_cksum (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .clr     (ck_clr),
        .add     (ck_add),
        .data    (bus.din),
        .expected(ck_ref),
        .match   (ck_match)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        ver_d    = ver_q;
        typ_d    = typ_q;
        len_d    = len_q;
        id0_d    = id0_q;
        id1_d    = id1_q;
        pkt_id_d = pkt_id_q;
        cks_d    = cks_q;
        cons_d   = cons_q;
        done_d   = 3'b000;
        ok_d     = 1'b0;
        err_d    = err_q;
        rd       = 1'b0;
        wr       = 3'b000;
        ck_clr   = 1'b0;
        ck_add   = 1'b0;

        hdr_err                 = '0;
        hdr_err[ERR_VERSION]    = (ver_q != VERSION[7:0]);
        hdr_err[ERR_TYPE]       = (type_mask(typ_q) == 3'b000);
        hdr_err[ERR_LEN]        = (len_q == 24'd0) || (32'(len_q) > MAX_LEN);
        hdr_err[ERR_HDR_CKSUM]  = !ck_match && !DISABLE_CHECKSUM;
        hdr_err[ERR_BODY_CKSUM] = 1'b0;

        unique case (state_q)
            StHdr: begin
                rd = RESET_N & ~bus.empty;
                if (rd) begin
                    ck_add = 1'b1;
                    case (cnt_q)
                        4'd0:    ver_d = bus.din;
                        4'd1:    typ_d = bus.din;
                        4'd4:    len_d[7:0] = bus.din;
                        4'd5:    len_d[15:8] = bus.din;
                        4'd6:    len_d[23:16] = bus.din;
                        4'd8:    id0_d = bus.din;
                        4'd9:    id1_d = bus.din;
                        default: ;
                    endcase
                    if (cnt_q == 4'(HDR_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = StHck;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StHck: begin
                rd = RESET_N & ~bus.empty;
                if (rd) begin
                    cks_d = ck_ref[31:8];
                    if (cnt_q == 4'(CKSUM_LEN - 1)) begin
                        cnt_d = '0;
                        if (|hdr_err) begin
                            err_d   = err_q | {3'b000, hdr_err};
                            state_d = StErr;
                        end else begin
                            ck_clr   = 1'b1;
                            rem_d    = len_q;
                            cons_d   = type_mask(typ_q);
                            pkt_id_d = {id1_q, id0_q};
                            state_d  = StBody;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StBody: begin
                // The selected consumer's full flag stalls the FIFO directly.
                rd = RESET_N & ~bus.empty & ~|(bus.full & cons_q);
                wr = rd ? cons_q : 3'b000;
                if (rd) begin
                    ck_add = 1'b1;
                    rem_d  = rem_q - 24'd1;
                    if (rem_q == 24'd1) begin
                        state_d = StBck;
                    end
                end
            end
            StBck: begin
                rd = RESET_N & ~bus.empty;
                if (rd) begin
                    cks_d = ck_ref[31:8];
                    if (cnt_q == 4'(CKSUM_LEN - 1)) begin
                        cnt_d  = '0;
                        done_d = cons_q;
                        ok_d   = ck_match | DISABLE_CHECKSUM;
                        if (!ck_match && !DISABLE_CHECKSUM) begin
                            err_d[ERR_BODY_CKSUM] = 1'b1;
                        end
                        ck_clr  = 1'b1;
                        state_d = StHdr;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            // Stream alignment is lost; only reset leaves this state.
            StErr: ;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= StHdr;
            cnt_q    <= '0;
            rem_q    <= '0;
            ver_q    <= '0;
            typ_q    <= '0;
            len_q    <= '0;
            id0_q    <= '0;
            id1_q    <= '0;
            pkt_id_q <= '0;
            cks_q    <= '0;
            cons_q   <= '0;
            done_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            ver_q    <= ver_d;
            typ_q    <= typ_d;
            len_q    <= len_d;
            id0_q    <= id0_d;
            id1_q    <= id1_d;
            pkt_id_q <= pkt_id_d;
            cks_q    <= cks_d;
            cons_q   <= cons_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign bus.rd_en    = rd;
    assign bus.wr_en    = wr;
    assign bus.dout     = bus.din;
    assign bus.pkt_id   = pkt_id_q;
    assign bus.pkt_done = done_q;
    assign bus.pkt_ok   = ok_q;
    assign bus.err      = err_q;

endmodule
